// File: rtl/rdi_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module   : rdi_rx_buffer
// Brief    : Receive FIFO feeding rdi_data to the memory stage. A source
//            pushes words over valid/ready; each unstalled rdi in MEM pops
//            one word. Stalls the pipeline on empty and flags dropped words.
// Revision : 1.0 - initial release
// ============================================================================
module rdi_rx_buffer #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    input  logic                       rdi_mem,
    input  logic                       stall_mem,
    output logic [WIDTH-1:0]           rdi_data,
    output logic                       rdi_stall,
    output logic                       rdi_avail,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf,
    input  logic                       clr_ovf
);

    localparam int                AW      = $clog2(DEPTH);
    localparam int                CW      = AW + 1;
    localparam logic [CW-1:0]     C_DEPTH = CW'(DEPTH);
    localparam logic [AW-1:0]     C_PTR_1 = AW'(1);
    localparam logic [CW-1:0]     C_CNT_1 = CW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [CW-1:0]    r_count;
    logic             r_ovf;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_drop;

    // Occupancy flags and the handshake decisions for this cycle.
    always_comb begin
        w_empty = (r_count == '0);
        w_full  = (r_count == C_DEPTH);
        w_push  = in_valid && !w_full;
        w_drop  = in_valid && w_full;
        w_pop   = rdi_mem && !w_empty && !stall_mem;
    end

    // Storage array; contents are don't-care after reset so it carries none.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= in_data;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + C_PTR_1;
            end
            if (w_pop) begin
                r_rp <= r_rp + C_PTR_1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_CNT_1;
                2'b01:   r_count <= r_count - C_CNT_1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    // Outputs: head word gated to zero when empty, stall request on empty rdi.
    always_comb begin
        in_ready  = !w_full;
        rdi_avail = !w_empty;
        count     = r_count;
        ovf       = r_ovf;
        rdi_stall = rdi_mem && w_empty;
        rdi_data  = w_empty ? '0 : r_mem[r_rp];
    end

endmodule
`default_nettype wire

// File: tb/tb_rdi_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rdi_rx_buffer
// Brief    : Self-checking bench for rdi_rx_buffer: queue-based reference
//            model compared every cycle, plus directed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rdi_rx_buffer;

    localparam int DEPTH = 8;
    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready;
    logic             rdi_mem = 1'b0;
    logic             stall_mem = 1'b0;
    logic [WIDTH-1:0] rdi_data;
    logic             rdi_stall;
    logic             rdi_avail;
    logic [3:0]       count;
    logic             ovf;
    logic             clr_ovf = 1'b0;

    int errors = 0;
    int checks = 0;

    rdi_rx_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .rdi_mem   (rdi_mem),
        .stall_mem (stall_mem),
        .rdi_data  (rdi_data),
        .rdi_stall (rdi_stall),
        .rdi_avail (rdi_avail),
        .count     (count),
        .ovf       (ovf),
        .clr_ovf   (clr_ovf)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain queue of buffered words plus the sticky flag.
    logic [WIDTH-1:0] q[$];
    bit               m_ovf;

    // Model update from the rules: pop head if unstalled rdi, push if room, else drop.
    always @(posedge clk or negedge rst_n) begin
        bit can_push, do_pop;
        if (!rst_n) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            can_push = in_valid && (q.size() < DEPTH);
            do_pop   = rdi_mem && !stall_mem && (q.size() > 0);
            if (do_pop) void'(q.pop_front());
            if (can_push) q.push_back(in_data);
            if (in_valid && !can_push) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
        end
    end

    // Every-cycle comparison of all outputs against the model, away from the edge.
    always @(negedge clk) begin
        chk("m_in_ready",  {31'd0, in_ready},  {31'd0, q.size() < DEPTH});
        chk("m_rdi_avail", {31'd0, rdi_avail}, {31'd0, q.size() != 0});
        chk("m_count",     {28'd0, count},     q.size());
        chk("m_ovf",       {31'd0, ovf},       {31'd0, m_ovf});
        chk("m_rdi_stall", {31'd0, rdi_stall}, {31'd0, rdi_mem && (q.size() == 0)});
        chk("m_rdi_data",  rdi_data,           (q.size() != 0) ? q[0] : 32'd0);
    end

    task automatic drive(input logic v, input logic [31:0] d, input logic rm,
                         input logic sm, input logic co);
        in_valid  = v;
        in_data   = d;
        rdi_mem   = rm;
        stall_mem = sm;
        clr_ovf   = co;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] held;

        // Reset state, with rdi_mem high to see rdi_stall follow it.
        drive(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        tick(); tick();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_avail",    {31'd0, rdi_avail}, 32'd0);
        chk("rst_count",    {28'd0, count}, 32'd0);
        chk("rst_data",     rdi_data, 32'd0);
        chk("rst_stall",    {31'd0, rdi_stall}, 32'd1);
        rst_n = 1'b1;
        idle();
        tick();

        // Single push then a one-cycle rdi.
        drive(1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0);
        #1 chk("p1_ready", {31'd0, in_ready}, 32'd1);
        tick();
        idle();
        chk("p1_count", {28'd0, count}, 32'd1);
        chk("p1_avail", {31'd0, rdi_avail}, 32'd1);
        chk("p1_data",  rdi_data, 32'hA5A5_0001);
        drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        chk("p1_pop_count", {28'd0, count}, 32'd0);
        chk("p1_pop_data",  rdi_data, 32'd0);

        // Fill to full, drop one, then drain in order across the pointer wrap.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 32'h10 + i, 1'b0, 1'b0, 1'b0);
            tick();
        end
        idle();
        chk("fill_count", {28'd0, count}, 32'd8);
        chk("fill_ready", {31'd0, in_ready}, 32'd0);
        drive(1'b1, 32'h18, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        chk("drop_ovf",   {31'd0, ovf}, 32'd1);
        chk("drop_count", {28'd0, count}, 32'd8);
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
            #1 chk("drain_data", rdi_data, 32'h10 + i);
            tick();
        end
        idle();
        chk("drain_count", {28'd0, count}, 32'd0);

        // clr_ovf alone clears the flag.
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        chk("clr_ovf", {31'd0, ovf}, 32'd0);

        // Simultaneous push/pop at count 3 and at full.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h20 + i, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'h23, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        chk("pp3_count", {28'd0, count}, 32'd3);
        chk("pp3_head",  rdi_data, 32'h21);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h24 + i, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'h29, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        chk("pp8_count", {28'd0, count}, 32'd7);
        chk("pp8_ovf",   {31'd0, ovf}, 32'd1);
        chk("pp8_head",  rdi_data, 32'h22);
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
            tick();
        end
        idle();

        // rdi while empty stalls; a word arrives, stall drops, then it pops.
        drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        #1 chk("empty_stall", {31'd0, rdi_stall}, 32'd1);
        tick();
        chk("empty_count", {28'd0, count}, 32'd0);
        drive(1'b1, 32'hBEEF, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        #1 chk("beef_stall", {31'd0, rdi_stall}, 32'd0);
        chk("beef_data", rdi_data, 32'hBEEF);
        tick();
        idle();
        chk("beef_pop_count", {28'd0, count}, 32'd0);

        // stall_mem holds the pop off; releasing it gives exactly one pop.
        drive(1'b1, 32'h31, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h32, 1'b0, 1'b0, 1'b0);
        tick();
        held = rdi_data;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
            tick();
            chk("hold_count", {28'd0, count}, 32'd2);
            chk("hold_data",  rdi_data, held);
        end
        drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        chk("release_count", {28'd0, count}, 32'd1);
        chk("release_data",  rdi_data, 32'h32);

        // Drop coincident with clr_ovf keeps ovf set.
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 32'h40 + i, 1'b0, 1'b0, 1'b0);
            tick();
        end
        chk("pre_setclr_ovf", {31'd0, ovf}, 32'd0);
        drive(1'b1, 32'h47, 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        chk("setclr_ovf", {31'd0, ovf}, 32'd1);

        // Asynchronous reset mid-fill at count 5.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h50 + i, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
        chk("mid_count", {28'd0, count}, 32'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", {28'd0, count}, 32'd0);
        chk("arst_avail", {31'd0, rdi_avail}, 32'd0);
        chk("arst_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_data",  rdi_data, 32'd0);
        chk("arst_ovf",   {31'd0, ovf}, 32'd0);
        idle();
        tick();
        rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(99) < 55), $urandom,
                  ($urandom_range(99) < 50), ($urandom_range(99) < 25),
                  ($urandom_range(99) < 5));
            if (($urandom_range(999)) == 0) rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
        end

        idle();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rdi_rx_buffer.md
# rdi_rx_buffer

Receive-side buffer that supplies `rdi_data` to the processor memory stage. An external word source (game-link receiver, controller decoder, etc.) pushes 32-bit words over a valid/ready interface. The memory stage consumes one word per executed `rdi` instruction. The block stores words in a circular FIFO, presents the head word combinationally, requests a pipeline stall when an `rdi` finds the buffer empty, and flags dropped words.

## Interface
Parameters:
- `DEPTH`, default 8: FIFO entries; power of two, ≥ 2.
- `WIDTH`, default 32: word width; must match `rdi_data` consumer.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  source presents `in_data` this cycle.
- `in_data`  in  WIDTH  word from source.
- `in_ready`  out  1  buffer can accept; equals `!full`.
- `rdi_mem`  in  1  `rdi` instruction is in the MEM stage this cycle.
- `stall_mem`  in  1  MEM stage held by the pipeline; suppresses pop.
- `rdi_data`  out  WIDTH  head word; 0 when empty.
- `rdi_stall`  out  1  `rdi_mem && empty`; to hazard unit.
- `rdi_avail`  out  1  `!empty`; software-visible status.
- `count`  out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH.
- `ovf`  out  1  sticky: at least one word dropped.
- `clr_ovf`  in  1  clears `ovf`.

## Operation
- Storage: `DEPTH` x `WIDTH` register array with write pointer `wp` and read pointer `rp`. Each pointer is $clog2(DEPTH) bits and wraps modulo `DEPTH`. `count` is an explicit register.
- `empty = (count == 0)`, `full = (count == DEPTH)`.
- Push: when `in_valid && in_ready`, write `in_data` at `wp` and increment `wp`.
- Drop: when `in_valid && !in_ready`, the word is discarded and `ovf` is set. The array and pointers are unchanged.
- Pop: when `rdi_mem && !empty && !stall_mem`, increment `rp`. The current head is consumed; the memory stage registers `rdi_data` into its pipeline FF on the same edge.
- Push and pop in the same cycle: both take effect and `count` is unchanged.
  - When full, `in_ready`=0, so the push is a drop even if a pop occurs that cycle. There is no combinational ready-from-pop path.
  - When empty, there is no pop and the pushed word becomes the head next cycle. There is no bypass.
- `rdi_stall`: asserted combinationally whenever `rdi_mem && empty`, regardless of `stall_mem`. The hazard unit holds the `rdi` in MEM until a word arrives; the pop then happens on the first cycle that is non-empty and unstalled.
- `rdi_data`: `mem[rp]` when non-empty, else 0.
- `ovf`: set on any drop and cleared by `clr_ovf`. A set and a clear in the same cycle leave `ovf`=1 (set wins).

## Timing
- Reset (async assert, sync release): `wp`=0, `rp`=0, `count`=0, `ovf`=0. Outputs are then `in_ready`=1, `rdi_avail`=0, `rdi_stall`=`rdi_mem`, `rdi_data`=0. Array contents are don't-care.
- Push-to-visible latency: 1 cycle. A word accepted at edge N appears on `rdi_data`/`rdi_avail` after edge N.
- Pop takes effect at the edge; the next head is visible in the following cycle.
- `in_ready`, `rdi_avail` and `count` are registered-state functions only; no input-to-output combinational path.
- `rdi_stall` and `rdi_data` depend combinationally on state and `rdi_mem` only.
- Reset mid-operation discards all buffered words and clears `ovf` immediately.

## Test plan
- Reset, then push 0xA5A5_0001: `in_ready`=1 throughout. After 1 edge, `count`=1, `rdi_avail`=1, `rdi_data`=0xA5A5_0001. A pulse of `rdi_mem` for 1 cycle gives `count`=0 and `rdi_data`=0.
- Fill: push 0x10..0x17 back-to-back with `DEPTH`=8. After the 8th edge, `count`=8 and `in_ready`=0. Push 0x18: it is dropped, `ovf`=1, `count`=8. Eight pops return 0x10..0x17 in order, exercising pointer wrap.
- Simultaneous push and pop at `count`=3: `count` stays 3 and ordering is preserved. At `count`=8 with push and pop: `count`=7, the push is dropped, `ovf`=1.
- `rdi_mem`=1 while empty: `rdi_stall`=1 and no pointer change. Push 0xBEEF on edge N: at cycle N+1 `rdi_stall`=0 and `rdi_data`=0xBEEF. Pop at edge N+1.
- `rdi_mem`=1 with `stall_mem`=1 and `count`=2: no pop for 3 cycles and `rdi_data` is stable. Release `stall_mem`: exactly one pop.
- `clr_ovf` alone: `ovf` goes 1→0. `clr_ovf` coincident with a drop: `ovf` stays 1. Assert `rst_n` low mid-fill at `count`=5: all outputs go to their reset values asynchronously.
